// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) polynomial divider: FSM states and width helpers
// derived from the operand width N of the matching carry-less multiplier.
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product / dividend width for N-bit operands.
  function automatic int prod_w(input int n);
    return 2 * n - 1;
  endfunction

  // Remainder width; degree is strictly below the divisor's, so N-1 bits suffice.
  function automatic int rem_w(input int n);
    return (n > 1) ? n - 1 : 1;
  endfunction

  // Bit-position counter width, large enough to hold 2N-2.
  function automatic int cnt_w(input int n);
    return (2 * n - 1 > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

  // Bit-index width for an N-bit vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf2_deg_detect.sv
// Combinational priority encoder: index of the highest set bit of vec, plus an all-zero flag.
// No state, no handshake; msb reads 0 when vec is zero.
module gf2_deg_detect
  import gf2_pkg::*;
#(
  parameter int W  = 4,
  parameter int IW = idx_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] msb,
  output logic          zero
);

  always_comb begin
    msb  = '0;
    zero = (vec == '0);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) msb = IW'(i);
    end
  end

endmodule

// File: rtl/gf2_poly_divider_seq.sv
// Bit-serial GF(2) long divider: 2N-1 DIV cycles after accept (1 for a zero divisor).
// Result is held in DONE until out_ready; no new operands are accepted until then.
module gf2_poly_divider_seq
  import gf2_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*N-2:0]       dividend,
  input  logic [N-1:0]         divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N-2:0]       quotient,
  output logic [rem_w(N)-1:0]  remainder,
  output logic                 div_by_zero
);

  localparam int PW = prod_w(N);
  localparam int RW = rem_w(N);
  localparam int CW = cnt_w(N);
  localparam int IW = idx_w(N);

  state_t          state;
  logic [PW-1:0]   dvd_q;
  logic [N-1:0]    dvs_q;
  logic [IW-1:0]   d_q;
  logic [N-1:0]    r_q;
  logic [PW-1:0]   q_q;
  logic [CW-1:0]   cnt_q;

  logic [IW-1:0]   dvs_msb;
  logic            dvs_zero;

  logic [N-1:0]    r_shift;
  logic            qbit;
  logic [N-1:0]    r_next;
  logic [PW-1:0]   q_next;
  logic [RW-1:0]   rem_masked;

  gf2_deg_detect #(
    .W  (N),
    .IW (IW)
  ) u_deg (
    .vec  (divisor),
    .msb  (dvs_msb),
    .zero (dvs_zero)
  );

  // deg(r) < d before each shift, so the shifted value never overflows N bits
  // and XOR with the divisor always clears bit d.
  always_comb begin
    r_shift    = (r_q << 1) | N'(dvd_q[cnt_q]);
    qbit       = r_shift[d_q];
    r_next     = qbit ? (r_shift ^ dvs_q) : r_shift;
    q_next     = (q_q << 1) | PW'(qbit);
    rem_masked = '0;
    for (int i = 0; i < RW; i++) begin
      if (i < int'(d_q)) rem_masked[i] = r_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            d_q   <= dvs_msb;
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= CW'(PW - 1);
            if (dvs_zero) begin
              state       <= DONE;
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state       <= DONE;
            quotient    <= q_next;
            remainder   <= rem_masked;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_gf2_poly_divider_seq.sv
// Self-checking bench for gf2_poly_divider_seq (N=4): directed table, handshake corners,
// exhaustive multiply-then-divide round trips and random dividends against a reference.
module tb_gf2_poly_divider_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf2_poly_divider_seq #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [6:0] dvd;
    logic [3:0] dvs;
    logic [6:0] q;
    logic [2:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Schoolbook carry-less product; equals any correct Karatsuba variant.
  function automatic logic [10:0] clmul(input logic [6:0] a, input logic [3:0] b);
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ (11'(a) << i);
    end
    return p;
  endfunction

  // Textbook polynomial long division on plain integers.
  function automatic void ref_div(input logic [6:0] a, input logic [3:0] b,
                                  output logic [6:0] q, output logic [2:0] r);
    int          db;
    logic [10:0] rem;
    db  = -1;
    rem = 11'(a);
    q   = '0;
    r   = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) db = i;
    end
    if (db >= 0) begin
      for (int i = 6; i >= db; i--) begin
        if (rem[i]) begin
          rem      = rem ^ (11'(b) << (i - db));
          q[i - db] = 1'b1;
        end
      end
      r = rem[2:0];
    end
  endfunction

  // Starts and ends on a falling edge; lat counts rising edges from the accept edge (=1).
  task automatic do_div(input logic [6:0] a, input logic [3:0] b,
                        output logic [6:0] q, output logic [2:0] r,
                        output logic dz, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    lat      = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 7'($urandom);
      divisor  = 4'($urandom);
    end while (!out_valid && lat < 40);
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] q, eq, hq;
    logic [2:0] r, er, hr;
    logic       dz, hdz;
    logic [6:0] a;
    logic [3:0] b;
    int         lat;

    vt[0] = '{dvd: 7'h31, dvs: 4'b0111, q: 7'h0B, r: 3'b000, dz: 1'b0, lat: 8};
    vt[1] = '{dvd: 7'h40, dvs: 4'b1011, q: 7'h0B, r: 3'b101, dz: 1'b0, lat: 8};
    vt[2] = '{dvd: 7'h5A, dvs: 4'b0001, q: 7'h5A, r: 3'b000, dz: 1'b0, lat: 8};
    vt[3] = '{dvd: 7'h5A, dvs: 4'b0000, q: 7'h00, r: 3'b000, dz: 1'b1, lat: 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_div(vt[i].dvd, vt[i].dvs, q, r, dz, lat);
      chk($sformatf("vec%0d_quotient", i), 32'(q), 32'(vt[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(r), 32'(vt[i].r));
      chk($sformatf("vec%0d_div_by_zero", i), 32'(dz), 32'(vt[i].dz));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      release_out();
    end

    // Backpressure: result must hold for 5 cycles while new operands are offered.
    do_div(7'h40, 4'b1011, hq, hr, hdz, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      dividend = 7'($urandom);
      divisor  = 4'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quotient", 32'(quotient), 32'h0B);
      chk("hold_remainder", 32'(remainder), 32'h5);
      chk("hold_div_by_zero", 32'(div_by_zero), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset while DIV holds cnt=3 (four edges after accept, counting the accept edge).
    in_valid = 1'b1;
    dividend = 7'h31;
    divisor  = 4'b0111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_div_out_valid", 32'(out_valid), 32'd0);
    chk("mid_div_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    do_div(7'h31, 4'b0111, q, r, dz, lat);
    chk("after_abort_quotient", 32'(q), 32'h0B);
    chk("after_abort_remainder", 32'(r), 32'd0);
    chk("after_abort_latency", 32'(lat), 32'd8);
    release_out();

    // Every nonzero product of 4-bit factors divides back exactly.
    for (int ia = 1; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        a = 7'(clmul(7'(ia), 4'(ib)));
        do_div(a, 4'(ib), q, r, dz, lat);
        chk($sformatf("oka_q a=%0h b=%0h", ia, ib), 32'(q), 32'(ia));
        chk($sformatf("oka_r a=%0h b=%0h", ia, ib), 32'(r), 32'd0);
        chk($sformatf("oka_dz a=%0h b=%0h", ia, ib), 32'(dz), 32'd0);
        release_out();
      end
    end

    for (int k = 0; k < 150; k++) begin
      a = 7'($urandom);
      b = 4'($urandom_range(0, 15));
      ref_div(a, b, eq, er);
      do_div(a, b, q, r, dz, lat);
      chk($sformatf("rnd_q %0h/%0h", a, b), 32'(q), 32'(eq));
      chk($sformatf("rnd_r %0h/%0h", a, b), 32'(r), 32'(er));
      chk($sformatf("rnd_dz %0h/%0h", a, b), 32'(dz), 32'(b == 4'd0));
      chk($sformatf("rnd_lat %0h/%0h", a, b), 32'(lat), (b == 4'd0) ? 32'd1 : 32'd8);
      if (b != 4'd0) begin
        chk($sformatf("rnd_relation %0h/%0h", a, b),
            32'(clmul(q, b) ^ 11'(r)), 32'(a));
      end
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
